// File: rtl/lf_edge_interval_pkg.sv
// Shared defaults and FSM state encodings for the LF edge interval timer.
// Pure declarations: no latency or backpressure of its own.
// Imported by the top and the FIFO.
package lf_edge_interval_pkg;

    localparam int LFI_CNT_W      = 15;
    localparam int LFI_FIFO_DEPTH = 8;
    localparam int LFI_PRESCALE   = 1;

    typedef enum logic [1:0] {
        LFI_IDLE       = 2'd0,
        LFI_WAIT_FIRST = 2'd1,
        LFI_MEASURE    = 2'd2
    } lfi_state_t;

endpackage

// File: rtl/lf_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a synchronous flush.
// Latency: a write is visible on o_rd_data one cycle later.
// Backpressure: writes are ignored when full unless a read happens in the same cycle.
module lf_sync_fifo
    import lf_edge_interval_pkg::*;
#(
    parameter int W     = LFI_CNT_W + 1,
    parameter int DEPTH = LFI_FIFO_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_wr_en,
    input  logic [W-1:0]               i_wr_data,
    input  logic                       i_rd_en,
    output logic [W-1:0]               o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == LVL_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_level = r_count;
    assign w_rd    = i_rd_en & ~o_empty;
    assign w_wr    = i_wr_en & (~o_full | w_rd);

    // Head is forced to zero while empty so no stale entry leaks out.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_wr && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lf_edge_interval.sv
// Measures pck0-tick intervals between LF edge events and queues {level, interval} words.
// Latency: word pushed at the end of the edge cycle, valid on o_iv_data the next cycle.
// Backpressure: valid/ready pop; a full FIFO with no pop drops the word and sets sticky overflow.
module lf_edge_interval
    import lf_edge_interval_pkg::*;
#(
    parameter int CNT_W      = LFI_CNT_W,
    parameter int FIFO_DEPTH = LFI_FIFO_DEPTH,
    parameter int PRESCALE   = LFI_PRESCALE
) (
    input  logic                          i_pck0,
    input  logic                          i_nreset,
    input  logic                          i_enable,
    input  logic                          i_lf_ed_toggle_mode,
    input  logic                          i_edge_state,
    input  logic                          i_edge_toggle,
    output logic [CNT_W:0]                o_iv_data,
    output logic                          o_iv_valid,
    input  logic                          i_iv_ready,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    lfi_state_t       r_state;
    logic             r_sel_q;
    logic             r_mode_q;
    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic             r_overflow;

    logic             w_sel;
    logic             w_mode_chg;
    logic             w_event;
    logic             w_tick;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_fifo_wr;

    assign w_sel      = i_lf_ed_toggle_mode ? i_edge_toggle : i_edge_state;
    assign w_mode_chg = (i_lf_ed_toggle_mode != r_mode_q);
    assign w_event    = i_enable & (w_sel != r_sel_q) & ~w_mode_chg;
    assign w_tick     = (r_pre == PRE_W'(PRESCALE - 1));

    // The event cycle's own tick is included so the word covers t1-t0 cycles, not t1-t0-1.
    assign w_cnt_inc  = (w_tick && (r_cnt != '1)) ? r_cnt + CNT_W'(1) : r_cnt;

    assign w_push     = w_event & (r_state == LFI_MEASURE);
    assign w_pop      = o_iv_valid & i_iv_ready;
    assign w_fifo_wr  = w_push & (~w_full | w_pop);
    assign o_iv_valid = ~w_empty;
    assign o_overflow = r_overflow;

    // sel_q and mode_q track even while disabled, so enable rise never looks like an edge.
    always_ff @(posedge i_pck0 or negedge i_nreset) begin
        if (!i_nreset) begin
            r_sel_q  <= 1'b0;
            r_mode_q <= 1'b0;
        end else begin
            r_sel_q  <= w_sel;
            r_mode_q <= i_lf_ed_toggle_mode;
        end
    end

    always_ff @(posedge i_pck0 or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state <= LFI_IDLE;
        end else if (!i_enable) begin
            r_state <= LFI_IDLE;
        end else if (w_mode_chg) begin
            r_state <= LFI_WAIT_FIRST;
        end else if (w_event) begin
            r_state <= LFI_MEASURE;
        end else if (r_state == LFI_IDLE) begin
            r_state <= LFI_WAIT_FIRST;
        end
    end

    always_ff @(posedge i_pck0 or negedge i_nreset) begin
        if (!i_nreset) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (!i_enable || w_mode_chg || w_event) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
            r_cnt <= w_cnt_inc;
        end
    end

    always_ff @(posedge i_pck0 or negedge i_nreset) begin
        if (!i_nreset) begin
            r_overflow <= 1'b0;
        end else if (!i_enable) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    lf_sync_fifo #(
        .W     (CNT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_pck0),
        .i_rst_n   (i_nreset),
        .i_flush   (~i_enable),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data ({w_sel, w_cnt_inc}),
        .i_rd_en   (w_pop),
        .o_rd_data (o_iv_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (o_fifo_level)
    );

endmodule

// File: tb/tb_lf_edge_interval.sv
// Directed bench for lf_edge_interval: a PRESCALE=1 instance and a PRESCALE=4 instance share stimulus.
module tb_lf_edge_interval;

    logic        clk = 1'b0;
    logic        nreset;
    logic        enable;
    logic        mode;
    logic        e_state;
    logic        e_toggle;
    logic        ready;

    logic [15:0] iv_data;
    logic        iv_valid;
    logic        ovf;
    logic [3:0]  level;
    logic [15:0] iv_data4;
    logic        iv_valid4;
    logic        ovf4;
    logic [3:0]  level4;

    int ncomp;
    int nfail;
    int cyc;

    always #5 clk = ~clk;

    lf_edge_interval #(.CNT_W(15), .FIFO_DEPTH(8), .PRESCALE(1)) u_dut (
        .i_pck0              (clk),
        .i_nreset            (nreset),
        .i_enable            (enable),
        .i_lf_ed_toggle_mode (mode),
        .i_edge_state        (e_state),
        .i_edge_toggle       (e_toggle),
        .o_iv_data           (iv_data),
        .o_iv_valid          (iv_valid),
        .i_iv_ready          (ready),
        .o_overflow          (ovf),
        .o_fifo_level        (level)
    );

    lf_edge_interval #(.CNT_W(15), .FIFO_DEPTH(8), .PRESCALE(4)) u_dut4 (
        .i_pck0              (clk),
        .i_nreset            (nreset),
        .i_enable            (enable),
        .i_lf_ed_toggle_mode (mode),
        .i_edge_state        (e_state),
        .i_edge_toggle       (e_toggle),
        .o_iv_data           (iv_data4),
        .o_iv_valid          (iv_valid4),
        .i_iv_ready          (ready),
        .o_overflow          (ovf4),
        .o_fifo_level        (level4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: outputs settled and inputs for the next cycle may be driven.
    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic go(input int c);
        while (cyc < c) tick();
    endtask

    int          ivl [10] = '{22, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    logic [15:0] expw [10];
    logic [15:0] fillw [9];
    int          t;

    initial begin
        ncomp = 0; nfail = 0; cyc = 0;
        nreset = 1'b0; enable = 1'b0; mode = 1'b1;
        e_state = 1'b0; e_toggle = 1'b1; ready = 1'b0;
        #12;
        chk("rst_valid", iv_valid, 0);
        chk("rst_data", iv_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_level", level, 0);

        @(negedge clk);
        nreset = 1'b1;
        repeat (4) tick();

        // Basic toggle mode: edges at 10 (arm), 30, 75
        enable = 1'b1;
        cyc = 0;
        go(10);  e_toggle = 1'b0;
        go(30);  chk("first_edge_no_word", iv_valid, 0);
        e_toggle = 1'b1;
        go(31);  chk("valid_at_31", iv_valid, 1);
        chk("word0", iv_data, 16'h8014);
        chk("ps4_word0", iv_data4, 16'h8005);
        go(75);  e_toggle = 1'b0;
        go(76);  chk("level_2", level, 2);
        chk("head_stable", iv_data, 16'h8014);
        ready = 1'b1;
        go(77);  chk("word1", iv_data, 16'h002D);
        chk("level_after_pop", level, 1);
        go(78);  chk("drained_valid", iv_valid, 0);
        ready = 1'b0;

        // Prescale: 100 then 103 cycles apart
        go(175); e_toggle = 1'b1;
        go(278); e_toggle = 1'b0;
        go(279); chk("ps4_level", level4, 2);
        chk("ps4_100", iv_data4, 16'h8019);
        chk("ps1_100", iv_data, 16'h8064);
        ready = 1'b1;
        go(280); chk("ps4_103_floor", iv_data4, 16'h0019);
        chk("ps1_103", iv_data, 16'h0067);
        go(281); chk("ps_drained", iv_valid, 0);
        ready = 1'b0;

        // Saturation: 40000 cycles without an edge
        go(40278); e_toggle = 1'b1;
        go(40279); chk("saturate", iv_data, 16'hFFFF);
        chk("ps4_40000", iv_data4, 16'hA710);
        ready = 1'b1;
        go(40280); chk("sat_drained", iv_valid, 0);
        ready = 1'b0;

        // Overflow: 10 edges with ready low
        t = 40278;
        for (int k = 0; k < 10; k++) begin
            t += ivl[k];
            go(t);
            e_toggle = ~e_toggle;
            expw[k] = {e_toggle, 15'(ivl[k])};
        end
        go(t + 1); chk("full_level", level, 8);
        chk("overflow_set", ovf, 1);
        chk("full_head", iv_data, expw[0]);
        go(t + 5); chk("stall_stable", iv_data, expw[0]);
        ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d", k), iv_data, expw[k]);
            tick();
        end
        chk("drain_empty", iv_valid, 0);
        ready = 1'b0;

        // Clear overflow, then full + pop + push in one cycle
        enable = 1'b0;
        t = cyc;
        go(t + 1); chk("ovf_cleared", ovf, 0);
        enable = 1'b1;
        go(t + 3); e_toggle = ~e_toggle;
        for (int k = 0; k < 9; k++) begin
            go(t + 3 + 5 * (k + 1));
            e_toggle = ~e_toggle;
            fillw[k] = {e_toggle, 15'd5};
            if (k == 8) ready = 1'b1;
        end
        go(t + 49); chk("fpp_level", level, 8);
        chk("fpp_no_ovf", ovf, 0);
        chk("fpp_head", iv_data, fillw[1]);
        t = cyc;
        go(t + 7); chk("fpp_tail", iv_data, fillw[8]);
        go(t + 8); chk("fpp_empty", iv_valid, 0);
        ready = 1'b0;

        // Mode change with differing sources: no word, next edge only re-arms
        t = cyc;
        e_state = ~e_toggle;
        go(t + 2); mode = 1'b0;
        go(t + 3); chk("modechg_no_word", level, 0);
        go(t + 7); e_state = ~e_state;
        go(t + 8); chk("rearm_no_word", level, 0);
        go(t + 17); e_state = ~e_state;
        go(t + 18); chk("post_rearm_word", iv_data, {e_state, 15'd10});
        chk("post_rearm_level", level, 1);
        enable = 1'b0;
        go(t + 19); chk("flush_level", level, 0);
        chk("flush_valid", iv_valid, 0);
        chk("flush_ovf", ovf, 0);
        enable = 1'b1;

        // Async reset mid-operation
        t = cyc;
        go(t + 2); e_state = ~e_state;
        go(t + 6); e_state = ~e_state;
        go(t + 7); chk("pre_reset_word", iv_data, {e_state, 15'd4});
        #1 nreset = 1'b0;
        #1;
        chk("async_rst_valid", iv_valid, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_data", iv_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
